// File: rtl/latch_bank_sched.sv
// latch_bank_sched: round-robin sequencer for a shared bank of clear/preset
// latches. Each granted transaction walks SETUP -> OPEN -> HOLD -> CHECK,
// drives exactly one strobe during OPEN, and reads the bank back in CHECK.
module latch_bank_sched #(
  parameter int W         = 4,
  parameter int NREQ      = 4,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] op,
  input  logic [W*NREQ-1:0] data,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic              err,
  output logic [W-1:0]      lat_d,
  output logic              lat_en,
  output logic              lat_pre,
  output logic              lat_clr,
  input  logic [W-1:0]      lat_q
);

  localparam int MAXC = (SETUP_CYC > PULSE_CYC) ?
                        ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                        ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int CW = $clog2(MAXC + 1);
  localparam int PW = $clog2(NREQ);

  typedef enum logic [2:0] {IDLE, SETUP, OPEN, HOLD, CHECK} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic [PW-1:0]   gnt, gnt_n;
  logic [1:0]      opr, opr_n;
  logic [W-1:0]    expv, expv_n;
  logic [W-1:0]    d_n;
  logic [NREQ-1:0] ack_n;
  logic            busy_n, err_n, en_n, pre_n, clr_n;
  logic            found;
  int unsigned     sel;

  // Round-robin pick: first requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      int unsigned idx;
      idx = (32'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Next-state, counter and registered-output next values.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    gnt_n   = gnt;
    opr_n   = opr;
    expv_n  = expv;
    d_n     = lat_d;
    err_n   = err;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_n   = PW'(sel);
          opr_n   = op[2*sel +: 2];
          cnt_n   = '0;
          state_n = SETUP;
          case (op[2*sel +: 2])
            2'b01:   begin expv_n = '1; d_n = '0; end
            2'b10:   begin expv_n = '0; d_n = '0; end
            default: begin expv_n = data[W*sel +: W]; d_n = data[W*sel +: W]; end
          endcase
        end
      end
      SETUP: begin
        if (cnt == CW'(SETUP_CYC - 1)) begin
          cnt_n   = '0;
          state_n = OPEN;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      OPEN: begin
        if (cnt == CW'(PULSE_CYC - 1)) begin
          cnt_n   = '0;
          state_n = HOLD;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (cnt == CW'(HOLD_CYC - 1)) begin
          cnt_n   = '0;
          state_n = CHECK;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      CHECK: begin
        if (lat_q != expv) err_n = 1'b1;
        ptr_n   = (gnt == PW'(NREQ - 1)) ? '0 : gnt + 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    busy_n = (state_n != IDLE);
    ack_n  = '0;
    if (state_n == CHECK) ack_n[gnt] = 1'b1;
    en_n  = (state_n == OPEN) && (opr != 2'b01) && (opr != 2'b10);
    pre_n = (state_n == OPEN) && (opr == 2'b01);
    clr_n = (state_n == OPEN) && (opr == 2'b10);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= '0;
      gnt     <= '0;
      opr     <= '0;
      expv    <= '0;
      ack     <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
      lat_d   <= '0;
      lat_en  <= 1'b0;
      lat_pre <= 1'b0;
      lat_clr <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ptr     <= ptr_n;
      gnt     <= gnt_n;
      opr     <= opr_n;
      expv    <= expv_n;
      ack     <= ack_n;
      busy    <= busy_n;
      err     <= err_n;
      lat_d   <= d_n;
      lat_en  <= en_n;
      lat_pre <= pre_n;
      lat_clr <= clr_n;
    end
  end

endmodule

// File: tb/tb_latch_bank_sched.sv
// Self-checking bench for latch_bank_sched with a behavioural latch bank and a
// transaction-level reference for grant order, strobe windows and err.
module tb_latch_bank_sched;

  localparam int W = 4;
  localparam int NREQ = 4;
  localparam int SETUP_CYC = 1;
  localparam int PULSE_CYC = 2;
  localparam int HOLD_CYC = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] op;
  logic [W*NREQ-1:0] data;
  logic [NREQ-1:0]   ack;
  logic              busy, err, lat_en, lat_pre, lat_clr;
  logic [W-1:0]      lat_d, lat_q, lm, stuck_val;
  logic              stuck;

  int unsigned ncmp = 0;
  int unsigned nfail = 0;
  int unsigned m_ptr = 0;
  logic        m_err = 1'b0;

  always #5 clk = ~clk;

  latch_bank_sched #(
    .W(W), .NREQ(NREQ), .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .data(data), .ack(ack), .busy(busy),
    .err(err), .lat_d(lat_d), .lat_en(lat_en), .lat_pre(lat_pre), .lat_clr(lat_clr),
    .lat_q(lat_q)
  );

  // Behavioural latch bank: clear dominates preset, preset dominates enable.
  always_latch begin
    if (lat_clr)      lm <= '0;
    else if (lat_pre) lm <= '1;
    else if (lat_en)  lm <= lat_d;
  end
  assign lat_q = stuck ? stuck_val : lm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    ncmp++;
    assert (obs === expd) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("strobe_excl", 32'($onehot0({lat_en, lat_pre, lat_clr})), 1);
  endtask

  // One full transaction from IDLE through CHECK and back to IDLE.
  task automatic do_txn(input bit drop, input bit scram, output logic [NREQ-1:0] ack_seen);
    int unsigned     g;
    bit              fnd;
    logic [1:0]      o;
    logic [W-1:0]    dd, expv, dexp;
    logic [2:0]      sexp;
    logic [NREQ-1:0] one;
    g = 0;
    fnd = 0;
    for (int k = 0; k < NREQ; k++) begin
      int unsigned idx;
      idx = (m_ptr + k) % NREQ;
      if (!fnd && req[idx]) begin fnd = 1; g = idx; end
    end
    o  = op[2*g +: 2];
    dd = data[W*g +: W];
    case (o)
      2'b01:   begin expv = '1; dexp = '0; sexp = 3'b010; end
      2'b10:   begin expv = '0; dexp = '0; sexp = 3'b001; end
      default: begin expv = dd; dexp = dd; sexp = 3'b100; end
    endcase
    one = '0;
    one[g] = 1'b1;

    step();
    chk("grant_busy", busy, 1);
    chk("grant_lat_d", lat_d, dexp);
    chk("setup_strobes", {lat_en, lat_pre, lat_clr}, 0);
    chk("setup_ack", ack, 0);
    if (scram) begin
      op   = 2*NREQ'($urandom);
      data = W*NREQ'($urandom);
      req  = NREQ'($urandom) | one;
    end
    for (int i = 1; i < SETUP_CYC; i++) begin
      step();
      chk("setup_strobes", {lat_en, lat_pre, lat_clr}, 0);
    end
    for (int i = 0; i < PULSE_CYC; i++) begin
      step();
      chk("open_strobes", {lat_en, lat_pre, lat_clr}, sexp);
      chk("open_lat_d", lat_d, dexp);
      chk("open_ack", ack, 0);
    end
    for (int i = 0; i < HOLD_CYC; i++) begin
      step();
      chk("hold_strobes", {lat_en, lat_pre, lat_clr}, 0);
      chk("hold_lat_d", lat_d, dexp);
    end
    step();
    ack_seen = ack;
    chk("check_ack", ack, one);
    chk("check_busy", busy, 1);
    chk("check_err", err, m_err);
    if (!stuck) chk("readback", lat_q, expv);
    if (stuck && (stuck_val != expv)) m_err = 1'b1;
    m_ptr = (g + 1) % NREQ;
    if (drop) req[g] = 1'b0;
    step();
    chk("idle_ack", ack, 0);
    chk("idle_busy", busy, 0);
    chk("idle_err", err, m_err);
    chk("idle_lat_d", lat_d, dexp);
  endtask

  initial begin
    logic [NREQ-1:0] a;
    rst = 1'b1; req = '0; op = '0; data = '0; stuck = 1'b0; stuck_val = '0;

    // Reset then idle.
    step(); step();
    rst = 1'b0;
    chk("rst_outs", {ack, busy, err, lat_d, lat_en, lat_pre, lat_clr}, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_quiet", {ack, busy, lat_en, lat_pre, lat_clr}, 0);
    end

    // Single load of A on requester 0.
    op[1:0] = 2'b00; data[3:0] = 4'hA; req = 4'b0001;
    do_txn(1, 0, a);

    // Preset then clear on requester 1.
    op[3:2] = 2'b01; req = 4'b0010;
    do_txn(1, 0, a);
    op[3:2] = 2'b10; req = 4'b0010;
    do_txn(1, 0, a);

    // Round-robin fairness with all requesters held, starting from ptr 0.
    rst = 1'b1; step(); rst = 1'b0; m_ptr = 0; m_err = 1'b0;
    req = '1; op = 8'b11_10_01_00; data = 16'h1234;
    for (int k = 0; k < 8; k++) begin
      do_txn(0, 0, a);
      chk("rr_order", a, 32'(1) << (k % NREQ));
    end
    req = '0;

    // Randomized transactions, including back-to-back and reserved opcodes.
    for (int k = 0; k < 24; k++) begin
      if (req == '0) req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      op   = 2*NREQ'($urandom);
      data = W*NREQ'($urandom);
      do_txn(bit'($urandom_range(0, 1)), 1, a);
    end
    req = '0;

    // Readback fault is sticky through later good transactions.
    stuck = 1'b1; stuck_val = 4'h0;
    op[1:0] = 2'b00; data[3:0] = 4'h5; req = 4'b0001;
    do_txn(1, 0, a);
    chk("err_set", err, 1);
    stuck = 1'b0;
    op[5:4] = 2'b01; req = 4'b0100;
    do_txn(1, 0, a);
    op[7:6] = 2'b00; data[15:12] = 4'h9; req = 4'b1000;
    do_txn(1, 0, a);
    chk("err_sticky", err, 1);

    // Mid-transaction reset during OPEN; pointer returns to 0.
    op[3:2] = 2'b00; data[7:4] = 4'h3; req = 4'b0010;
    do_txn(1, 0, a);
    op[1:0] = 2'b00; data[3:0] = 4'h7; req = 4'b0001;
    step();
    step();
    chk("pre_abort_en", lat_en, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = '1;
    chk("abort_outs", {ack, busy, err, lat_d, lat_en, lat_pre, lat_clr}, 0);
    m_ptr = 0; m_err = 1'b0;
    op = '0; data = 16'hC3A5;
    do_txn(1, 0, a);
    chk("post_abort_grant", a, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/latch_bank_sched.md
Name: latch_bank_sched

Overview:
- Sequences a shared bank of W level-sensitive latches with clear and preset controls (the latch-with-clear and latch-with-set/clear cells used in our formal and mapping tests) between NREQ requesters.
- Each transaction is one of: load data, preset all, or clear all.
- Round-robin arbitration picks the requester.
- Enforces setup, open and hold windows around the latch control strobes, then reads the latch outputs back and flags mismatches.

Parameters:
- W, 4, latch bank data width.
- NREQ, 4, number of requesters (2..8).
- SETUP_CYC, 1, cycles lat_d is stable before a strobe asserts (>=1).
- PULSE_CYC, 2, cycles a strobe (lat_en, lat_pre or lat_clr) is held high (>=1).
- HOLD_CYC, 1, cycles lat_d stays stable after the strobe falls (>=1).

Ports:
- clk, input, 1, single clock; all logic on its rising edge.
- rst, input, 1, synchronous active-high reset.
- req, input, NREQ, per-requester request level; held until ack.
- op, input, 2*NREQ, per-requester opcode, slice i at [2i+1:2i]: 00 load, 01 preset, 10 clear, 11 reserved (treated as load).
- data, input, W*NREQ, per-requester load data, slice i at [W*i+W-1:W*i].
- ack, output, NREQ, one-cycle completion pulse to the granted requester.
- busy, output, 1, high in any state other than IDLE.
- err, output, 1, sticky readback-mismatch flag; cleared only by rst.
- lat_d, output, W, data to the latch bank D inputs.
- lat_en, output, 1, latch enable strobe.
- lat_pre, output, 1, latch preset strobe.
- lat_clr, output, 1, latch clear strobe.
- lat_q, input, W, latch bank Q outputs (readback).

Behaviour:
- Reset (rst=1 at a rising edge) sets:
  - state=IDLE.
  - ack=0, busy=0, err=0.
  - lat_d=0, lat_en=0, lat_pre=0, lat_clr=0.
  - round-robin pointer=0.
  - All counters=0.
- Reset mid-transaction aborts it on the next edge: no ack is issued and all strobes are low from the following cycle.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE -> SETUP -> OPEN -> HOLD -> CHECK -> IDLE.
- IDLE:
  - If any req bit is 1, grant the lowest index >= ptr, wrapping modulo NREQ.
  - Latch the granted index, the opcode, the data and the expected value. Expected = data for load, all-ones for preset, all-zeros for clear.
  - Drive lat_d = data for load, 0 otherwise. Go to SETUP.
  - If no req bit is 1, stay in IDLE.
- SETUP: stay SETUP_CYC cycles with all strobes low, then go to OPEN.
- OPEN:
  - Exactly one strobe is high for PULSE_CYC cycles: lat_en for load, lat_pre for preset, lat_clr for clear.
  - The three strobes are mutually exclusive in every cycle; this is a checked invariant.
  - Then go to HOLD.
- HOLD: all strobes low, lat_d unchanged, for HOLD_CYC cycles. Then go to CHECK.
- CHECK:
  - Single cycle. Compare lat_q with expected. On mismatch, set err=1 (sticky).
  - Pulse ack[granted]=1 for exactly this cycle.
  - Set ptr = (granted+1) mod NREQ. Go to IDLE.
- lat_d:
  - Changes only on the IDLE->SETUP transition.
  - Otherwise holds its value, including in IDLE after a transaction completes.
- Transaction length is SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles after grant. With the defaults this is 5 cycles: SETUP, OPEN, OPEN, HOLD, CHECK.
- Back-to-back: a requester still asserting req in the cycle after its ack is eligible again. Its priority is lowest, behind the rotated pointer.
- Requests that drop before grant are ignored. A req, op or data change after grant has no effect on the current transaction.
- Simultaneous requests: pointer order only. The opcode does not affect priority.
- Counters are sized to clog2(max(SETUP_CYC, PULSE_CYC, HOLD_CYC)+1) bits and never wrap.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 -> all outputs 0, busy=0, state stays IDLE for 10 cycles.
- Single load, W=4, defaults: req=0001, op0=00, data0=4'hA, lat_q tied to a latch model.
  - lat_d=A one cycle after grant.
  - lat_en high for exactly 2 cycles starting 1 cycle later.
  - ack[0] pulses on cycle 5 after grant.
  - err stays 0.
- Preset then clear: requester 1 op=01, then op=10.
  - lat_pre then lat_clr each high for 2 cycles; never overlapping with each other or with lat_en.
  - Readback F then 0; err=0.
- Round-robin fairness: req=1111 held for 8 transactions, from ptr=0 -> ack order 0,1,2,3,0,1,2,3. No requester is granted twice in a row while others are pending.
- Readback fault: latch model stuck at lat_q=4'h0, load data=4'h5 -> err=1 at the CHECK cycle and stays 1 through subsequent good transactions until rst.
- Mid-transaction reset: rst=1 during OPEN -> lat_en=0 from the next cycle, no ack, busy=0. The next request is granted from ptr=0.
